// File: rtl/picomips_isa_pkg.sv
// rtl/picomips_isa_pkg.sv - picoMIPS opcodes, field positions and instruction kinds
package picomips_isa_pkg;

  localparam logic [3:0] OP_ADD   = 4'h0;
  localparam logic [3:0] OP_MUL   = 4'h1;
  localparam logic [3:0] OP_IN    = 4'h2;
  localparam logic [3:0] OP_OUT   = 4'h3;
  localparam logic [3:0] OP_LOADW = 4'h4;
  localparam logic [3:0] OP_ADDI  = 4'hB;
  localparam logic [3:0] OP_HALT  = 4'hC;
  localparam logic [3:0] OP_LOADI = 4'hE;
  localparam logic [3:0] OP_MOVE  = 4'hF;

  localparam int OPC_LSB = 12;
  localparam int RD_LSB  = 9;
  localparam int RS_LSB  = 6;
  localparam int IMM_LSB = 0;

  typedef enum logic [3:0] {
    K_ADD   = 4'd0,
    K_MUL   = 4'd1,
    K_IN    = 4'd2,
    K_OUT   = 4'd3,
    K_LOADW = 4'd4,
    K_ADDI  = 4'd5,
    K_LOADI = 4'd6,
    K_MOVE  = 4'd7,
    K_HALT  = 4'd8
  } instr_kind_e;

endpackage

// File: rtl/instr_encoder_loader_if.sv
// rtl/instr_encoder_loader_if.sv - request handshake and program memory write bus
interface instr_encoder_loader_if #(
  parameter int AW = 8
);
  logic          req_valid;
  logic          req_ready;
  logic [3:0]    req_kind;
  logic [2:0]    req_rd;
  logic [2:0]    req_rs;
  logic [7:0]    req_imm;
  logic          pm_we;
  logic [AW-1:0] pm_addr;
  logic [15:0]   pm_wdata;

  modport master (
    output req_valid, req_kind, req_rd, req_rs, req_imm,
    input  req_ready, pm_we, pm_addr, pm_wdata
  );

  modport slave (
    input  req_valid, req_kind, req_rd, req_rs, req_imm,
    output req_ready, pm_we, pm_addr, pm_wdata
  );
endinterface

// File: rtl/instr_encoder_loader_pack.sv
// rtl/instr_encoder_loader_pack.sv - combinational kind+fields to 16-bit picoMIPS word
module instr_pack
  import picomips_isa_pkg::*;
(
  input  logic [3:0]  kind,
  input  logic [2:0]  rd,
  input  logic [2:0]  rs,
  input  logic [7:0]  imm,
  output logic [15:0] word,
  output logic        legal,
  output logic        is_halt
);

  always_comb begin
    word    = '0;
    legal   = 1'b1;
    is_halt = 1'b0;
    case (kind)
      K_ADD: begin
        word[OPC_LSB +: 4] = OP_ADD;
        word[RD_LSB  +: 3] = rd;
        word[RS_LSB  +: 3] = rs;
      end
      K_MUL: begin
        word[OPC_LSB +: 4] = OP_MUL;
        word[RD_LSB  +: 3] = rd;
        word[RS_LSB  +: 3] = rs;
      end
      K_IN: begin
        word[OPC_LSB +: 4] = OP_IN;
        word[RD_LSB  +: 3] = rd;
      end
      K_OUT: begin
        word[OPC_LSB +: 4] = OP_OUT;
        word[RD_LSB  +: 3] = rd;
      end
      K_LOADW: begin
        word[OPC_LSB +: 4] = OP_LOADW;
        word[RD_LSB  +: 3] = rd;
      end
      // Immediate forms keep bit 8 clear; imm occupies [7:0].
      K_ADDI: begin
        word[OPC_LSB +: 4] = OP_ADDI;
        word[RD_LSB  +: 3] = rd;
        word[IMM_LSB +: 8] = imm;
      end
      K_LOADI: begin
        word[OPC_LSB +: 4] = OP_LOADI;
        word[RD_LSB  +: 3] = rd;
        word[IMM_LSB +: 8] = imm;
      end
      K_MOVE: begin
        word[OPC_LSB +: 4] = OP_MOVE;
        word[RD_LSB  +: 3] = rd;
        word[RS_LSB  +: 3] = rs;
      end
      K_HALT: begin
        word[OPC_LSB +: 4] = OP_HALT;
        is_halt            = 1'b1;
      end
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// rtl/instr_encoder_loader.sv - picoMIPS encoder streaming words into program memory; optional PROGRAM_CHECKSUM_EN
module instr_encoder_loader
  import picomips_isa_pkg::*;
#(
  parameter int AW        = 8,
  parameter int IMEM_BASE = 0
)(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  instr_encoder_loader_if.slave bus,
  output logic                  busy,
  output logic                  done,
  output logic [AW:0]           prog_len,
  output logic                  err_illegal,
  output logic                  err_overflow
`ifdef PROGRAM_CHECKSUM_EN
  ,
  output logic [15:0]           checksum
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE, S_ERR} state_e;

  localparam logic [AW-1:0] LAST_ADDR = '1;
  localparam logic [AW-1:0] BASE_ADDR = AW'(IMEM_BASE);

  state_e        state, state_nxt;
  logic [AW-1:0] addr;
  logic          wr_valid;
  logic [15:0]   wr_data;
  logic [15:0]   pack_word;
  logic          pack_legal, pack_halt;
  logic          xfer, overflow_hit, accept_write;
  logic [AW-1:0] next_addr;

  instr_pack u_pack (
    .kind    (bus.req_kind),
    .rd      (bus.req_rd),
    .rs      (bus.req_rs),
    .imm     (bus.req_imm),
    .word    (pack_word),
    .legal   (pack_legal),
    .is_halt (pack_halt)
  );

  assign xfer = bus.req_valid && bus.req_ready;
  // Address this transfer would land on once the write already in flight retires.
  assign next_addr    = wr_valid ? addr + AW'(1) : addr;
  assign overflow_hit = xfer && pack_legal && !pack_halt && (next_addr == LAST_ADDR);
  assign accept_write = xfer && pack_legal && !overflow_hit;

  always_comb begin
    state_nxt = state;
    if (state == S_LOAD && xfer && pack_legal) begin
      if (pack_halt)
        state_nxt = S_DONE;
      else if (overflow_hit)
        state_nxt = S_ERR;
    end
    if (start)
      state_nxt = S_LOAD;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      addr        <= BASE_ADDR;
      wr_valid    <= 1'b0;
      wr_data     <= '0;
      prog_len    <= '0;
      err_illegal <= 1'b0;
`ifdef PROGRAM_CHECKSUM_EN
      checksum    <= '0;
`endif
    end else begin
      state       <= state_nxt;
      err_illegal <= xfer && !pack_legal && !start;
      if (start) begin
        addr     <= BASE_ADDR;
        wr_valid <= 1'b0;
        wr_data  <= '0;
        prog_len <= '0;
`ifdef PROGRAM_CHECKSUM_EN
        checksum <= '0;
`endif
      end else begin
        wr_valid <= accept_write;
        wr_data  <= accept_write ? pack_word : 16'h0000;
        if (wr_valid) begin
          addr     <= addr + AW'(1);
          prog_len <= prog_len + (AW+1)'(1);
`ifdef PROGRAM_CHECKSUM_EN
          checksum <= checksum + wr_data;
`endif
        end
      end
    end
  end

  // A start in the write cycle cancels that write on the memory port.
  assign bus.pm_we     = wr_valid && !start;
  assign bus.pm_addr   = addr;
  assign bus.pm_wdata  = wr_data;
  assign bus.req_ready = (state == S_LOAD);

  assign busy         = (state == S_LOAD);
  assign done         = (state == S_DONE);
  assign err_overflow = (state == S_ERR);

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
Encoder for the 16-bit picoMIPS instruction format, the inverse of the instruction decoder. It accepts symbolic instruction requests over a valid/ready handshake and packs each into a 16-bit word. It then streams the words into program memory at auto-incrementing addresses until a HALT is written. It sits between the host/test loader and the instruction memory write port.

Parameters:
AW, 8, program memory address width; depth = 2**AW words
IMEM_BASE, 0, first address written after start

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
start  input  1  one-cycle pulse; flushes pending write, sets address to IMEM_BASE, enters LOAD
req_valid  input  1  request present
req_ready  output  1  encoder can accept this cycle
req_kind  input  4  instruction kind enum (see package)
req_rd  input  3  destination / output register
req_rs  input  3  source register
req_imm  input  8  immediate
pm_we  output  1  program memory write strobe
pm_addr  output  AW  write address
pm_wdata  output  16  encoded instruction
busy  output  1  state == LOAD
done  output  1  HALT has been written
prog_len  output  AW+1  words written since start
err_illegal  output  1  one-cycle pulse on an accepted illegal kind
err_overflow  output  1  sticky; program exceeded memory

Behaviour:
- Reset: state IDLE; all outputs 0; address = IMEM_BASE; write stage empty.
- States: IDLE, LOAD, DONE, ERR. start moves any state to LOAD next edge; rst has priority over start.
- req_ready = (state==LOAD). Transfer occurs when req_valid && req_ready. req_ready does not depend on req_valid.
- Encoding uses fixed fields: opcode[15:12], rd[11:9], rs[8:6], imm[7:0]. All unused bits are 0.
  - ADD=0x0 (rd, rs); MUL=0x1 (rd, rs); IN=0x2 (rd); OUT=0x3 (rd); LOADW=0x4 (rd)
  - ADDI=0xB (rd, imm; bit8=0); LOADI=0xE (rd, imm; bit8=0); MOVE=0xF (rd, rs); HALT=0xC (all fields 0)
  - Fields not used by a kind are ignored, not checked.
- Latency: a transfer in cycle N produces pm_we=1 in cycle N+1, with the encoded word and the current address. The address increments after the write. Full throughput is one instruction per cycle.
- Illegal kinds (9-15): the request is consumed and err_illegal pulses in cycle N+1. No write occurs, the address is unchanged, and the state stays LOAD.
- HALT: the state moves to DONE at the edge ending cycle N. The HALT write is issued in cycle N+1, and done=1 from cycle N+1 onward. req_ready is 0 from cycle N+1.
- Overflow: the last address (2**AW-1) is reserved for HALT. A non-HALT transfer while the address equals 2**AW-1 is not written. In that case err_overflow is set, the state moves to ERR, and req_ready drops.
- ERR and DONE are left only via start or rst. start clears done and err_overflow, zeroes prog_len, and flushes any write pending in the start cycle (no pm_we next cycle).
- prog_len counts issued writes, HALT included.

Optional Feature:
PROGRAM_CHECKSUM_EN
- Defined: adds output checksum[15:0], the running sum mod 2**16 of every pm_wdata written since start. It is cleared by rst and start and updated in the write cycle, so the new value is visible the cycle after the write.
- Undefined: no checksum port and no logic.

Decomposition:
- Package picomips_isa_pkg holds the 4-bit opcode localparams (ADD, MUL, IN, OUT, LOADW, ADDI, HALT, LOADI, MOVE) and the field bit positions. It is shared with the decoder.
- The package also holds the instr_kind_e enum (K_ADD=0, K_MUL=1, K_IN=2, K_OUT=3, K_LOADW=4, K_ADDI=5, K_LOADI=6, K_MOVE=7, K_HALT=8).
- Sub-module instr_pack is a purely combinational kind+fields to word+legal function. The FSM, write stage and counters live in the top module.

Test Plan:
- start, then ADD rd=3 rs=5 -> next cycle pm_we=1, addr 0x00, data 0x0740; prog_len=1.
- Back-to-back ADDI rd=2 imm=0x7F, LOADI rd=7 imm=0xFF, MOVE rd=4 rs=2, OUT rd=1, HALT -> data 0xB47F, 0xEEFF, 0xF880, 0x3200, 0xC000 at addresses 0-4, one per cycle; done=1, req_ready=0, prog_len=5.
- Kind 12 between two ADDs -> err_illegal pulse once; the ADDs land at consecutive addresses 0, 1.
- AW=2: three non-HALT, then a fourth non-HALT -> the first three are written at 0-2, the fourth is not written, err_overflow=1, state ERR. A repeat with HALT as the fourth request instead -> HALT written at 3, done=1.
- start asserted the cycle after a transfer -> no pm_we that cycle, address back to 0, prog_len=0. rst during LOAD -> all outputs 0 the next cycle.
- PROGRAM_CHECKSUM_EN defined: writes 0x0740, 0xB47F, 0xC000 -> checksum 0x7BBF.
